// File: rtl/imem_stream_loader.sv
// Byte-stream loader that assembles little-endian 32-bit words into instruction memory and holds
// the core in reset until a complete program is written. Optional trailing checksum: LOADER_CKSUM_EN.
module imem_stream_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        StIdle, StHdr0, StHdr1, StData, StFin, StCks, StDone, StErr
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       count_q, count_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       word_q, word_d;
    logic [7:0]        cks_q, cks_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              accept;
    logic [15:0]       hdr_count;

`ifdef LOADER_CKSUM_EN
    assign s_ready = (state_q == StHdr0) || (state_q == StHdr1) || (state_q == StData) ||
                     (state_q == StCks);
`else
    assign s_ready = (state_q == StHdr0) || (state_q == StHdr1) || (state_q == StData);
`endif

    assign accept    = s_valid && s_ready;
    assign hdr_count = {s_data, count_q[7:0]};

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        cks_d        = cks_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cpu_rst_d    = cpu_rst_q;
        busy_d       = busy_q;
        done_d       = done_q;
        err_d        = err_q;
        words_d      = words_q;

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d    = StHdr0;
                    cpu_rst_d  = 1'b1;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    err_d      = 1'b0;
                    words_d    = '0;
                    byte_idx_d = '0;
                    cks_d      = '0;
                end
            end
            StHdr0: begin
                if (accept) begin
                    count_d[7:0] = s_data;
                    state_d      = StHdr1;
                end
            end
            StHdr1: begin
                if (accept) begin
                    count_d = hdr_count;
                    if (hdr_count == 16'd0) begin
`ifdef LOADER_CKSUM_EN
                        state_d = StCks;
`else
                        state_d   = StDone;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
`endif
                    end else if (32'(hdr_count) > MAX_WORDS) begin
                        state_d = StErr;
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    cks_d      = cks_q ^ s_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = words_q[ADDR_W-1:0];
                        imem_wdata_d = {s_data, word_q};
                        words_d      = words_q + 1'b1;
                        // StFin keeps s_ready low while the final write pulse is visible.
                        if (32'(words_q) + 32'd1 == 32'(count_q)) begin
                            state_d = StFin;
                        end
                    end else begin
                        word_d[8*int'(byte_idx_q) +: 8] = s_data;
                    end
                end
            end
            StFin: begin
`ifdef LOADER_CKSUM_EN
                state_d = StCks;
`else
                state_d   = StDone;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                cpu_rst_d = 1'b0;
`endif
            end
            StCks: begin
                if (accept) begin
                    busy_d = 1'b0;
                    if (s_data == cks_q) begin
                        state_d   = StDone;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            count_q      <= '0;
            byte_idx_q   <= '0;
            word_q       <= '0;
            cks_q        <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_rst_q    <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            words_q      <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            cks_q        <= cks_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_rst_q    <= cpu_rst_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            words_q      <= words_d;
        end
    end

    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign cpu_rst      = cpu_rst_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_q;

endmodule
